// File: rtl/sid_env_pkg.sv
// Shared types and tables for the multiplexed ADSR envelope generator.
// Contents:
//   env_state_t  - per-voice envelope phase (RELEASE=0, ATTACK=1, DECAY_SUS=2)
//   RATE_PERIOD  - rounds per rate step for each 4-bit rate code
//   EXP_THRESH / EXP_DIV - exponential decay/release divider table
//   exp_div()    - divisor lookup from the top 8 bits of the envelope
package sid_env_pkg;

    typedef enum logic [1:0] {
        StRelease  = 2'd0,
        StAttack   = 2'd1,
        StDecaySus = 2'd2
    } env_state_t;

    // Exponent counter width; holds 0..29.
    localparam int unsigned EXP_W = 5;

    localparam logic [15:0] RATE_PERIOD [16] = '{
        16'd9,    16'd32,   16'd63,   16'd95,   16'd149,  16'd220,  16'd267,   16'd313,
        16'd392,  16'd977,  16'd1954, 16'd3126, 16'd3907, 16'd11720, 16'd19532, 16'd31251
    };

    // Thresholds in descending order; EXP_DIV[5] applies below the last threshold.
    localparam logic [7:0]       EXP_THRESH [5] = '{8'h5D, 8'h36, 8'h1A, 8'h0E, 8'h06};
    localparam logic [EXP_W-1:0] EXP_DIV    [6] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd30};

    function automatic logic [EXP_W-1:0] exp_div(input logic [7:0] level);
        logic [EXP_W-1:0] div;
        div = EXP_DIV[5];
        // Walk from the lowest threshold up so the highest match wins.
        for (int i = 4; i >= 0; i--) begin
            if (level >= EXP_THRESH[i]) begin
                div = EXP_DIV[i];
            end
        end
        return div;
    endfunction

endpackage

// File: rtl/adsr_env_step.sv
// Combinational next-state calculation for the one voice serviced in the current slot.
// Ports:
//   state, env, rate_cnt, exp_cnt   - stored state of the serviced voice
//   attack, decay, sustain, rel     - config nibbles of the serviced voice
//   gate_rise, gate_fall            - gate edge seen at this slot
//   state_nxt, env_nxt, rate_cnt_nxt, exp_cnt_nxt - values to write back
module adsr_env_step
    import sid_env_pkg::*;
#(
    parameter int unsigned ENV_W  = 8,
    parameter int unsigned RATE_W = 15
) (
    input  env_state_t        state,
    input  logic [ENV_W-1:0]  env,
    input  logic [RATE_W-1:0] rate_cnt,
    input  logic [EXP_W-1:0]  exp_cnt,
    input  logic [3:0]        attack,
    input  logic [3:0]        decay,
    input  logic [3:0]        sustain,
    input  logic [3:0]        rel,
    input  logic              gate_rise,
    input  logic              gate_fall,
    output env_state_t        state_nxt,
    output logic [ENV_W-1:0]  env_nxt,
    output logic [RATE_W-1:0] rate_cnt_nxt,
    output logic [EXP_W-1:0]  exp_cnt_nxt
);

    localparam logic [ENV_W-1:0] EnvMax = '1;

    logic [3:0]       rate_code;
    logic [31:0]      period_m1;
    logic             step;
    logic [11:0]      sus_rep;
    logic [ENV_W-1:0] sus_level;
    logic [ENV_W-1:0] floor_level;
    logic [EXP_W-1:0] div;

    // {s,s,s} truncated from the top gives {s,s} left-aligned with nibble-filled low bits.
    assign sus_rep     = {sustain, sustain, sustain};
    assign sus_level   = sus_rep[11 -: ENV_W];
    assign floor_level = (state == StDecaySus) ? sus_level : '0;
    assign div         = exp_div(env[ENV_W-1 -: 8]);

    always_comb begin
        case (state)
            StAttack:   rate_code = attack;
            StDecaySus: rate_code = decay;
            default:    rate_code = rel;
        endcase
    end

    // ">=" rather than "==" so a shortened period steps immediately instead of wrapping.
    assign period_m1 = 32'(RATE_PERIOD[rate_code]) - 32'd1;
    assign step      = 32'(rate_cnt) >= period_m1;

    always_comb begin
        state_nxt    = state;
        env_nxt      = env;
        rate_cnt_nxt = rate_cnt;
        exp_cnt_nxt  = exp_cnt;
        if (gate_rise) begin
            state_nxt    = StAttack;
            rate_cnt_nxt = '0;
            exp_cnt_nxt  = '0;
        end else if (gate_fall) begin
            state_nxt    = StRelease;
            rate_cnt_nxt = '0;
            exp_cnt_nxt  = '0;
        end else begin
            rate_cnt_nxt = step ? '0 : rate_cnt + RATE_W'(1);
            if (step) begin
                case (state)
                    StAttack: begin
                        if (env >= EnvMax - ENV_W'(1)) begin
                            env_nxt     = EnvMax;
                            state_nxt   = StDecaySus;
                            exp_cnt_nxt = '0;
                        end else begin
                            env_nxt = env + ENV_W'(1);
                        end
                    end
                    StDecaySus, StRelease: begin
                        // Only every div-th rate step decrements; holds at the floor.
                        if (env > floor_level) begin
                            if (exp_cnt + EXP_W'(1) >= div) begin
                                env_nxt     = env - ENV_W'(1);
                                exp_cnt_nxt = '0;
                            end else begin
                                exp_cnt_nxt = exp_cnt + EXP_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/adsr_env_mux.sv
// Time-multiplexed ADSR envelope generator: NUM_VOICES voices share one step datapath,
// one voice serviced per clock slot in round-robin order.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   ena               - global enable; low freezes slot counter and envelope state
//   cfg_we, cfg_voice, cfg_addr, cfg_data - config byte write (addr 0: {decay,attack},
//                       addr 1: {release,sustain}); accepted regardless of ena
//   gate              - per-voice gate levels
//   env_out           - packed envelope levels, voice 0 in LSBs
//   env_state         - packed 2-bit per-voice state
module adsr_env_mux
    import sid_env_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 3,
    parameter int unsigned ENV_W      = 8,
    parameter int unsigned RATE_W     = 15,
    parameter int unsigned VOICE_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic                        cfg_we,
    input  logic [VOICE_W-1:0]          cfg_voice,
    input  logic                        cfg_addr,
    input  logic [7:0]                  cfg_data,
    input  logic [NUM_VOICES-1:0]       gate,
    output logic [NUM_VOICES*ENV_W-1:0] env_out,
    output logic [NUM_VOICES*2-1:0]     env_state
);

    env_state_t            state_q   [NUM_VOICES];
    logic [ENV_W-1:0]      env_q     [NUM_VOICES];
    logic [RATE_W-1:0]     rate_q    [NUM_VOICES];
    logic [EXP_W-1:0]      exp_q     [NUM_VOICES];
    logic [7:0]            cfg_ad_q  [NUM_VOICES];
    logic [7:0]            cfg_rs_q  [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_seen_q;
    logic [VOICE_W-1:0]    slot_q;

    env_state_t        state_nxt;
    logic [ENV_W-1:0]  env_nxt;
    logic [RATE_W-1:0] rate_nxt;
    logic [EXP_W-1:0]  exp_nxt;
    logic              gate_cur;
    logic              seen_cur;
    logic              last_slot;

    assign gate_cur  = gate[slot_q];
    assign seen_cur  = gate_seen_q[slot_q];
    assign last_slot = (slot_q == VOICE_W'(NUM_VOICES - 1));

    adsr_env_step #(
        .ENV_W  (ENV_W),
        .RATE_W (RATE_W)
    ) u_step (
        .state        (state_q[slot_q]),
        .env          (env_q[slot_q]),
        .rate_cnt     (rate_q[slot_q]),
        .exp_cnt      (exp_q[slot_q]),
        .attack       (cfg_ad_q[slot_q][3:0]),
        .decay        (cfg_ad_q[slot_q][7:4]),
        .sustain      (cfg_rs_q[slot_q][3:0]),
        .rel          (cfg_rs_q[slot_q][7:4]),
        .gate_rise    (gate_cur & ~seen_cur),
        .gate_fall    (~gate_cur & seen_cur),
        .state_nxt    (state_nxt),
        .env_nxt      (env_nxt),
        .rate_cnt_nxt (rate_nxt),
        .exp_cnt_nxt  (exp_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= '0;
            gate_seen_q <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_q[v] <= StRelease;
                env_q[v]   <= '0;
                rate_q[v]  <= '0;
                exp_q[v]   <= '0;
            end
        end else if (ena) begin
            slot_q <= last_slot ? '0 : slot_q + VOICE_W'(1);
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (slot_q == VOICE_W'(v)) begin
                    state_q[v]     <= state_nxt;
                    env_q[v]       <= env_nxt;
                    rate_q[v]      <= rate_nxt;
                    exp_q[v]       <= exp_nxt;
                    gate_seen_q[v] <= gate[v];
                end
            end
        end
    end

    // Out-of-range voice indices match no entry and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                cfg_ad_q[v] <= '0;
                cfg_rs_q[v] <= '0;
            end
        end else if (cfg_we) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (cfg_voice == VOICE_W'(v)) begin
                    if (cfg_addr) begin
                        cfg_rs_q[v] <= cfg_data;
                    end else begin
                        cfg_ad_q[v] <= cfg_data;
                    end
                end
            end
        end
    end

    always_comb begin
        env_out   = '0;
        env_state = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            env_out[v*ENV_W +: ENV_W] = env_q[v];
            env_state[v*2 +: 2]       = state_q[v];
        end
    end

endmodule
